// File: rtl/serial_add_sequencer_if.sv
// Operand-request and result handshake bundle for the bit-serial adder.
// master = requester/consumer side, slave = the adder itself.
interface serial_add_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start_valid, a, b, cin, done_ready,
    input  start_ready, busy, done_valid, sum, cout, ovf
  );

  modport slave (
    input  start_valid, a, b, cin, done_ready,
    output start_ready, busy, done_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused for WIDTH cycles,
// LSB first, with valid/ready handshakes for operands and result.
module sas_half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// state | meaning
// IDLE  | waiting for operands; start_ready=1, last result held on outputs
// RUN   | one sum bit produced per edge, LSB first
// DONE  | result valid, held until done_ready
module serial_add_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_add_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic ha0_s, ha0_c, fa_sum, ha1_c, fa_cout;

  sas_half_adder u_ha0 (.x(a_sh_q[0]), .y(b_sh_q[0]), .s(ha0_s),  .c(ha0_c));
  sas_half_adder u_ha1 (.x(ha0_s),     .y(carry_q),   .s(fa_sum), .c(ha1_c));
  assign fa_cout = ha0_c | ha1_c;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          state_d = RUN;
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        // On the MSB, carry_q is the carry into the sign bit.
        if (cnt_q == LAST_BIT) begin
          ovf_d   = carry_q ^ fa_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done_valid  = (state_q == DONE);
  assign bus.sum         = sum_sh_q;
  assign bus.cout        = carry_q;
  assign bus.ovf         = ovf_q;
endmodule
